uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer behind the my_uart receiver.
// Reports occupancy, empty/full/almost-full and a sticky overrun flag.
// Optional macro UART_RX_FIFO_FWFT_EN selects first-word-fall-through reads;
// when it is undefined, reads are registered with one cycle of latency.
module uart_rx_fifo #(
  parameter int N         = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   wr_valid_i,
  input  logic [N-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [N-1:0]           rd_data_o,
  output logic                   rd_valid_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   afull_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overrun_o,
  input  logic                   ovr_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;

  logic empty, full, pop_ok, wr_ok, wr_drop;

  // Status decode from the registered occupancy.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = empty;
  assign full_o  = full;
  assign afull_o = (count_q >= CW'(AFULL_LVL));
  assign count_o = count_q;
  assign overrun_o = overrun_q;

  // A pop needs data; a write needs room, which a same-cycle pop on a full buffer provides.
  assign pop_ok  = rd_en_i && !empty;
  assign wr_ok   = wr_valid_i && (!full || pop_ok);
  assign wr_drop = wr_valid_i && !wr_ok;

  // Next-state for pointers, occupancy and overrun flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_ok)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_drop)        overrun_d = 1'b1;
    else if (ovr_clr_i) overrun_d = 1'b0;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge sysclk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage array write port; a write coinciding with reset is discarded.
  always_ff @(posedge sysclk) begin
    // NOTE: the array has no reset; stale entries are unreachable once the pointers and count clear.
    if (wr_ok && !reset) mem_q[wr_ptr_q] <= wr_data_i;
  end

`ifdef UART_RX_FIFO_FWFT_EN
  // Head entry is presented combinationally; rd_en_i only acknowledges it.
  always_comb begin
    rd_valid_o = !empty;
    rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
  end
`else
  logic [N-1:0] rd_data_q, rd_data_d;
  logic         rd_valid_q, rd_valid_d;

  // Registered read: capture the head on an accepted pop, otherwise hold the data.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = pop_ok;
    if (pop_ok) rd_data_d = mem_q[rd_ptr_q];
  end

  // Read output register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

  localparam int N     = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic         sysclk = 1'b0;
  logic         reset;
  logic         wr_valid_i;
  logic [N-1:0] wr_data_i;
  logic         rd_en_i;
  logic [N-1:0] rd_data_o;
  logic         rd_valid_o;
  logic         empty_o, full_o, afull_o;
  logic [4:0]   count_o;
  logic         overrun_o;
  logic         ovr_clr_i;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  uart_rx_fifo #(.N(N), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .wr_valid_i(wr_valid_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en_i),
    .rd_data_o (rd_data_o),
    .rd_valid_o(rd_valid_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .afull_o   (afull_o),
    .count_o   (count_o),
    .overrun_o (overrun_o),
    .ovr_clr_i (ovr_clr_i)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] mq[$];
  logic         m_overrun = 1'b0;
  logic [N-1:0] m_rd_data = '0;
  logic         m_rd_valid = 1'b0;

  always @(posedge sysclk) begin
    bit do_pop, do_wr;
    if (reset) begin
      mq.delete();
      m_overrun  = 1'b0;
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
    end else begin
      do_pop = rd_en_i && (mq.size() > 0);
      do_wr  = wr_valid_i && ((mq.size() < DEPTH) || do_pop);
      m_rd_valid = 1'b0;
      if (do_pop) begin
        m_rd_data  = mq.pop_front();
        m_rd_valid = 1'b1;
      end
      if (do_wr) mq.push_back(wr_data_i);
      if (wr_valid_i && !do_wr) m_overrun = 1'b1;
      else if (ovr_clr_i)       m_overrun = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sysclk) begin
    if (chk_en) begin
      check("count", 32'(count_o), 32'(mq.size()));
      check("empty", 32'(empty_o), 32'(mq.size() == 0));
      check("full", 32'(full_o), 32'(mq.size() == DEPTH));
      check("afull", 32'(afull_o), 32'(mq.size() >= AFULL));
      check("overrun", 32'(overrun_o), 32'(m_overrun));
`ifdef UART_RX_FIFO_FWFT_EN
      check("rd_valid", 32'(rd_valid_o), 32'(mq.size() > 0));
      if (mq.size() > 0) check("rd_data", 32'(rd_data_o), 32'(mq[0]));
`else
      check("rd_valid", 32'(rd_valid_o), 32'(m_rd_valid));
      check("rd_data", 32'(rd_data_o), 32'(m_rd_data));
`endif
    end
  end

  // ---------------- capture of popped bytes ----------------
  logic [N-1:0] got[$];
`ifdef UART_RX_FIFO_FWFT_EN
  always @(posedge sysclk)
    if (!reset && rd_en_i && rd_valid_o) got.push_back(rd_data_o);
`else
  always @(negedge sysclk)
    if (chk_en && rd_valid_o) got.push_back(rd_data_o);
`endif

  // Apply one cycle of inputs; returns 1 time unit after the edge.
  task automatic step(input logic wv, input logic [N-1:0] wd, input logic re, input logic clr);
    wr_valid_i = wv;
    wr_data_i  = wd;
    rd_en_i    = re;
    ovr_clr_i  = clr;
    @(posedge sysclk);
    #1;
    wr_valid_i = 1'b0;
    rd_en_i    = 1'b0;
    ovr_clr_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] exp3 [3];
    exp3[0] = 8'h55; exp3[1] = 8'hA3; exp3[2] = 8'h0F;

    reset = 1'b1; wr_valid_i = 1'b0; wr_data_i = '0; rd_en_i = 1'b0; ovr_clr_i = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset state after idling.
    idle(5);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
`ifndef UART_RX_FIFO_FWFT_EN
    check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
`else
    check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
`endif

    // Three writes, three pops, order preserved.
    got.delete();
    for (int i = 0; i < 3; i++) step(1'b1, exp3[i], 1'b0, 1'b0);
    check("w3_count", 32'(count_o), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    check("p3_size", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3 && i < got.size(); i++) check("p3_data", 32'(got[i]), 32'(exp3[i]));
    check("p3_count", 32'(count_o), 32'd0);
    check("p3_empty", 32'(empty_o), 32'd1);

    // Fill to full, check almost-full and full thresholds, then overrun.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 10) check("afull_at11", 32'(afull_o), 32'd0);
      if (i == 11) check("afull_at12", 32'(afull_o), 32'd1);
      if (i == 14) check("full_at15", 32'(full_o), 32'd0);
    end
    check("full_at16", 32'(full_o), 32'd1);
    check("count16", 32'(count_o), 32'd16);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovr_set", 32'(overrun_o), 32'd1);
    check("ovr_count", 32'(count_o), 32'd16);
    got.delete();
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    check("drain_size", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++) check("drain_data", 32'(got[i]), 32'(i));
    check("ovr_held", 32'(overrun_o), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovr_clr", 32'(overrun_o), 32'd0);

    // Full buffer, simultaneous write and pop.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    got.delete();
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("wp_count", 32'(count_o), 32'd16);
    check("wp_ovr", 32'(overrun_o), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    check("wp_size", 32'(got.size()), 32'd17);
    if (got.size() == 17) begin
      check("wp_first", 32'(got[0]), 32'h00);
      check("wp_last", 32'(got[16]), 32'h77);
    end

    // Pop when empty: nothing comes out.
    got.delete();
    step(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    check("pe_size", 32'(got.size()), 32'd0);
    check("pe_count", 32'(count_o), 32'd0);

    // 32 interleaved write+pop cycles: both pointers wrap twice.
    for (int i = 0; i < 32; i++) step(1'b1, 8'(i) ^ 8'hA5, 1'b1, 1'b0);
    check("il_count", 32'(count_o), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    check("il_size", 32'(got.size()), 32'd32);
    for (int i = 0; i < 32 && i < got.size(); i++) check("il_data", 32'(got[i]), 32'(8'(i) ^ 8'hA5));

    // Reset with 5 stored and a write pending.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count_o), 32'd5);
    reset = 1'b1;
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    reset = 1'b0;
    check("mrst_count", 32'(count_o), 32'd0);
    check("mrst_empty", 32'(empty_o), 32'd1);
    got.delete();
    step(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    check("mrst_nodata", 32'(got.size()), 32'd0);

`ifdef UART_RX_FIFO_FWFT_EN
    // Fall-through: data visible the cycle after the write with no pop.
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("fwft_data", 32'(rd_data_o), 32'h3C);
    check("fwft_valid", 32'(rd_valid_o), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("fwft_empty", 32'(empty_o), 32'd1);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
